// File: rtl/fifo_sync_pkg.sv
// Shared types and sizing helpers for the fifo_sync family of FIFOs.
// No logic; elaboration-time only.
// Imported by the RTL and by the benches.
package fifo_sync_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Storage array: DEPTH x WIDTH registers, one synchronous write port, one async read port.
// Latency: write visible on the cycle after wr_en; read is combinational.
// Backpressure: none; the caller guarantees writes only target free slots.
module fifo_sync_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with standard/FWFT read, almost flags, occupancy count and sticky errors.
// Latency: standard mode data_out one cycle after read accept; FWFT head word visible once non-empty.
// Backpressure: writes refused while full, reads refused while empty; refused attempts set sticky errors.
module fifo_sync_flex
    import fifo_sync_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 32,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic                        clr_err,
    input  logic [FIFO_WIDTH-1:0]       data_in,
    output logic [FIFO_WIDTH-1:0]       data_out,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_empty,
    output logic                        almost_full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int         AW   = $clog2(FIFO_DEPTH);
    localparam int         CW   = cnt_w(FIFO_DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_flex: FIFO_DEPTH must be a power of 2 and >= 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH)) begin : g_bad_af
        $error("fifo_sync_flex: AF_THRESH out of range 1..FIFO_DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > FIFO_DEPTH - 1)) begin : g_bad_ae
        $error("fifo_sync_flex: AE_THRESH out of range 0..FIFO_DEPTH-1");
    end

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_try, rd_try, wr_acc, rd_acc;
    logic [FIFO_WIDTH-1:0] rd_dat;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_try = cs & wr_en;
    assign rd_try = cs & rd_en;
    // Gating with rst_n keeps a write in a reset cycle from landing in storage.
    assign wr_acc = rst_n & wr_try & ~full;
    assign rd_acc = rd_try & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_try & full)  overflow_d  = 1'b1;
        if (rd_try & empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_sync_ram #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_dat  (data_in),
        .rd_addr (rd_ptr_q),
        .rd_dat  (rd_dat)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign data_out = rd_dat;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) dout_d = rd_dat;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) dout_q <= '0;
            else        dout_q <= dout_d;
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: a standard-read and an FWFT instance share one stimulus stream,
// checked against a queue scoreboard plus a small flag/error model.
module tb_fifo_sync_flex;
    import fifo_sync_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 32;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0, cs = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [W-1:0] data_in = '0;

    logic [W-1:0] s_data_out, f_data_out;
    logic         s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic         f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [3:0]   s_count, f_count;

    fifo_sync_flex #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(W), .FWFT(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(s_data_out), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf));

    fifo_sync_flex #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(W), .FWFT(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(f_data_out), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf));

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] sb[$];
    bit           m_ovf, m_unf;
    logic [W-1:0] m_dout = '0;

    wire [51:0] obs = {s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_unf,
                       f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_unf, s_data_out};

    function automatic logic [9:0] exp_stat();
        int c;
        c = sb.size();
        return {4'(c), (c == 0), (c == DEPTH), (c <= AE), (c >= AF), m_ovf, m_unf};
    endfunction

    function automatic logic [51:0] exp_obs();
        return {exp_stat(), exp_stat(), m_dout};
    endfunction

    // One clock of stimulus; the model is updated from the pre-edge occupancy.
    task automatic drive(input bit c, input bit w, input bit r, input bit clr, input logic [W-1:0] d);
        bit full_m, empty_m, wacc, racc;
        logic [W-1:0] head;
        full_m  = (sb.size() == DEPTH);
        empty_m = (sb.size() == 0);
        wacc    = c && w && !full_m;
        racc    = c && r && !empty_m;
        head    = empty_m ? '0 : sb[0];
        cs = c; wr_en = w; rd_en = r; clr_err = clr; data_in = d;
        @(posedge clk);
        #1;
        if (racc) begin
            void'(sb.pop_front());
            m_dout = head;
        end
        if (wacc) sb.push_back(d);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (c && w && full_m)  m_ovf = 1'b1;
        if (c && r && empty_m) m_unf = 1'b1;
        cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; cs = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rst_n = 1'b1; cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        sb.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        if (obs !== exp_obs()) begin n_bad++; $display("FAIL reset_obs: got %h want %h", obs, exp_obs()); end
        n_cmp++;
        if ({s_empty, s_ae, s_full, s_af, s_count, s_data_out} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0}) begin
            n_bad++; $display("FAIL reset_const: empty=%b ae=%b full=%b af=%b cnt=%0d dout=%h",
                              s_empty, s_ae, s_full, s_af, s_count, s_data_out);
        end
        n_cmp++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, 0, 0, 32'(100 + i));
            if (obs !== exp_obs()) begin n_bad++; $display("FAIL fill[%0d]: got %h want %h", i, obs, exp_obs()); end
            n_cmp++;
        end
        if (!(s_full === 1'b1 && s_count === 4'd8)) begin
            n_bad++; $display("FAIL fill_full: full=%b cnt=%0d want 1/8", s_full, s_count);
        end
        n_cmp++;
        for (int i = 0; i < DEPTH; i++) begin
            if (f_data_out !== sb[0]) begin n_bad++; $display("FAIL fwft_head[%0d]: got %h want %h", i, f_data_out, sb[0]); end
            n_cmp++;
            drive(1, 0, 1, 0, '0);
            if (s_data_out !== 32'(100 + i)) begin n_bad++; $display("FAIL drain[%0d]: got %0d want %0d", i, s_data_out, 100 + i); end
            n_cmp++;
            if (obs !== exp_obs()) begin n_bad++; $display("FAIL drain_obs[%0d]: got %h want %h", i, obs, exp_obs()); end
            n_cmp++;
        end
    endtask

    task automatic test_fwft();
        drive(1, 1, 0, 0, 32'hA5A5);
        if (!(f_empty === 1'b0 && f_data_out === 32'hA5A5)) begin
            n_bad++; $display("FAIL fwft_show: empty=%b dout=%h want 0/a5a5", f_empty, f_data_out);
        end
        n_cmp++;
        drive(1, 0, 1, 0, '0);
        if (!(f_empty === 1'b1 && s_data_out === 32'hA5A5)) begin
            n_bad++; $display("FAIL fwft_pop: empty=%b std_dout=%h want 1/a5a5", f_empty, s_data_out);
        end
        n_cmp++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 32'(50 + i));
        for (int i = 0; i < 6; i++) drive(1, 0, 1, 0, '0);
        if (obs !== exp_obs()) begin n_bad++; $display("FAIL wrap_pre: got %h want %h", obs, exp_obs()); end
        n_cmp++;
        for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, 0, 32'(i));
        if (s_count !== 4'd8) begin n_bad++; $display("FAIL wrap_full: cnt=%0d want 8", s_count); end
        n_cmp++;
        for (int i = 0; i < DEPTH; i++) begin
            if (f_data_out !== 32'(i)) begin n_bad++; $display("FAIL wrap_fwft[%0d]: got %0d want %0d", i, f_data_out, i); end
            n_cmp++;
            drive(1, 0, 1, 0, '0);
            if (s_data_out !== 32'(i) || obs !== exp_obs()) begin
                n_bad++; $display("FAIL wrap_rd[%0d]: got %h want %h", i, obs, exp_obs());
            end
            n_cmp++;
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, 0, 32'(200 + i));
        drive(1, 1, 1, 0, 32'hAAAA);
        if (!(s_count === 4'd7 && s_ovf === 1'b1 && s_data_out === 32'd200)) begin
            n_bad++; $display("FAIL simul_full: cnt=%0d ovf=%b dout=%0d want 7/1/200", s_count, s_ovf, s_data_out);
        end
        n_cmp++;
        for (int i = 1; i < DEPTH; i++) begin
            drive(1, 0, 1, 0, '0);
            if (s_data_out === 32'hAAAA || obs !== exp_obs()) begin
                n_bad++; $display("FAIL simul_drain[%0d]: got %h want %h", i, obs, exp_obs());
            end
            n_cmp++;
        end
        drive(1, 1, 1, 0, 32'h5555);
        if (!(s_count === 4'd1 && s_unf === 1'b1 && s_data_out === 32'd207)) begin
            n_bad++; $display("FAIL simul_empty: cnt=%0d unf=%b dout=%0d want 1/1/207", s_count, s_unf, s_data_out);
        end
        n_cmp++;
        drive(1, 0, 1, 1, '0);
        if (obs !== exp_obs()) begin n_bad++; $display("FAIL simul_end: got %h want %h", obs, exp_obs()); end
        n_cmp++;
    endtask

    task automatic test_errors();
        for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, 0, 32'(300 + i));
        drive(1, 1, 0, 0, 32'hBAD);
        if (s_ovf !== 1'b1) begin n_bad++; $display("FAIL err_set: ovf=%b want 1", s_ovf); end
        n_cmp++;
        drive(0, 0, 0, 1, '0);
        if (s_ovf !== 1'b0 || obs !== exp_obs()) begin n_bad++; $display("FAIL err_clr: got %h want %h", obs, exp_obs()); end
        n_cmp++;
        drive(1, 1, 0, 1, 32'hBAD);
        if (s_ovf !== 1'b1 || f_ovf !== 1'b1) begin n_bad++; $display("FAIL err_set_wins: ovf=%b/%b want 1", s_ovf, f_ovf); end
        n_cmp++;
        drive(1, 0, 0, 1, '0);
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 1, 0, '0);
        if (s_data_out !== 32'd307 || obs !== exp_obs()) begin n_bad++; $display("FAIL err_drain: got %h want %h", obs, exp_obs()); end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 1, 0, '0);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 32'(400 + i));
        drive(1, 0, 1, 0, '0);
        drive(1, 1, 0, 0, 32'd405);
        if (s_count !== 4'd5 || s_unf !== 1'b1) begin n_bad++; $display("FAIL mid_pre: cnt=%0d unf=%b want 5/1", s_count, s_unf); end
        n_cmp++;
        apply_reset();
        if ({s_count, s_empty, s_data_out, s_ovf, s_unf} !== {4'd0, 1'b1, 32'd0, 1'b0, 1'b0} || obs !== exp_obs()) begin
            n_bad++; $display("FAIL mid_reset: got %h want %h", obs, exp_obs());
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 32'(500 + i));
        drive(1, 0, 1, 0, '0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 0, 32'(600 + i));
            if (s_count !== 4'd2 || obs !== exp_obs()) begin n_bad++; $display("FAIL cs_idle[%0d]: got %h want %h", i, obs, exp_obs()); end
            n_cmp++;
        end
        if (f_data_out !== 32'd501) begin n_bad++; $display("FAIL cs_head: got %0d want 501", f_data_out); end
        n_cmp++;
        drive(1, 0, 1, 0, '0);
        drive(1, 0, 1, 0, '0);
        if (s_data_out !== 32'd502 || obs !== exp_obs()) begin n_bad++; $display("FAIL cs_drain: got %h want %h", obs, exp_obs()); end
        n_cmp++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_fwft();
        test_wrap();
        test_simultaneous();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
